// File: rtl/byte_packer_pkg.sv
// Shared FSM encoding and sizing helpers for the byte packer.
package byte_packer_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_LANES      = 4;
    localparam int DEF_LANE_WIDTH = 8;
    localparam int IDX_WIDTH      = $clog2(DEF_LANES);
    localparam int CONCAT_WIDTH   = DEF_LANES * (DEF_LANE_WIDTH + 1);

    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int concat_width(input int lanes, input int lane_width);
        return lanes * (lane_width + 1);
    endfunction

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / packed-word-out handshake bundle for the byte packer.
interface byte_packer_if
    import byte_packer_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH
);

    logic                                 in_valid;
    logic                                 in_ready;
    logic [0:LANE_WIDTH-1]                in_data;
    logic                                 in_last;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [0:LANES-1][0:LANE_WIDTH-1]     out_lanes;
    logic [0:LANES-1]                     out_mask;
    logic [0:LANES*LANE_WIDTH+LANES-1]    out_concat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_lanes, out_mask, out_concat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_lanes, out_mask, out_concat
    );

endinterface

// File: rtl/packer_out_reg.sv
// Output register slice: holds one word until the consumer takes it.
module packer_out_reg #(
    parameter int WIDTH = 36
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    assign free = !out_valid || out_ready;

    // Data only changes on a load into a free slot, so it stays stable under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load && free) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_packer.sv
// Packs a serial byte stream into LANES-wide words with a lane-valid mask.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    byte_packer_if.slave  bus
);

    localparam int IDX_W = idx_width(LANES);
    localparam int CW    = concat_width(LANES, LANE_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef logic [0:LANES-1][0:LANE_WIDTH-1] lanes_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    lanes_t           acc_lanes;
    logic [0:LANES-1] acc_mask;
    lanes_t           merged_lanes;
    logic [0:LANES-1] merged_mask;
    logic             accept;
    logic             completing;
    logic             slot_free;
    logic             load;
    logic [CW-1:0]    load_word;
    logic [CW-1:0]    out_word;

    assign bus.in_ready = (state == FILL);
    assign accept       = bus.in_valid && (state == FILL);
    assign completing   = (idx == LAST_IDX) || bus.in_last;

    // Accumulator contents as they would be with the incoming byte written in.
    always_comb begin
        merged_lanes      = acc_lanes;
        merged_mask       = acc_mask;
        merged_lanes[idx] = bus.in_data;
        merged_mask[idx]  = 1'b1;
    end

    always_comb begin
        load      = 1'b0;
        load_word = {merged_lanes, merged_mask};
        unique case (state)
            FILL: load = accept && completing && slot_free;
            HOLD: begin
                load      = slot_free;
                load_word = {acc_lanes, acc_mask};
            end
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FILL;
            idx       <= '0;
            acc_lanes <= '0;
            acc_mask  <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        if (!completing) begin
                            acc_lanes <= merged_lanes;
                            acc_mask  <= merged_mask;
                            idx       <= idx + IDX_W'(1);
                        end else if (slot_free) begin
                            acc_lanes <= '0;
                            acc_mask  <= '0;
                            idx       <= '0;
                        end else begin
                            // Park the finished word until the output slot drains.
                            acc_lanes <= merged_lanes;
                            acc_mask  <= merged_mask;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        acc_lanes <= '0;
                        acc_mask  <= '0;
                        idx       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    packer_out_reg #(
        .WIDTH (CW)
    ) u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (load_word),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (out_word),
        .free      (slot_free)
    );

    assign {bus.out_lanes, bus.out_mask} = out_word;
    assign bus.out_concat                = out_word;

endmodule

// File: doc/byte_packer.md
# byte_packer

Collects a serial byte stream into one packed word of `LANES` lanes of `LANE_WIDTH` bits each, plus a lane-valid mask. It is the stage directly upstream of the packed-array consumer. Output `out_lanes` is a `[0:LANES-1][0:LANE_WIDTH-1]` packed array; `out_mask` is `[0:LANES-1]`. `out_concat` is `{out_lanes, out_mask}`, which is 36 bits at the default parameters. Both input and output use valid/ready handshakes, and the block sustains one byte per cycle.

## Interface
- `LANES`, 4, number of byte lanes per word (≥2)
- `LANE_WIDTH`, 8, bits per lane
- `clock` input 1 — single clock, all state updates on rising edge
- `reset` input 1 — synchronous, active-high
- `in_valid` input 1 — input byte valid
- `in_ready` output 1 — block accepts byte when `in_valid && in_ready`
- `in_data` input `[0:LANE_WIDTH-1]` — byte payload
- `in_last` input 1 — byte closes the current word (partial word allowed)
- `out_valid` output 1 — packed word valid
- `out_ready` input 1 — downstream accepts word when `out_valid && out_ready`
- `out_lanes` output `[0:LANES-1][0:LANE_WIDTH-1]` — packed word, lane 0 = first byte received
- `out_mask` output `[0:LANES-1]` — bit i set ⇔ lane i holds received data
- `out_concat` output `[0:LANES*LANE_WIDTH+LANES-1]` — `{out_lanes, out_mask}`

## Operation
- Accumulator: `LANES` lane registers, a mask, and a write index `idx` in `0..LANES-1`. An accepted byte goes to lane `idx` and sets mask bit `idx`.
- A byte is **completing** when `idx == LANES-1` or `in_last`.
- The output register holds `out_lanes`/`out_mask`/`out_valid`. The slot is free when `!out_valid || out_ready`.
- The FSM has two states:
  - FILL: `in_ready=1`.
    - Non-completing accept: `idx++`.
    - Completing accept with slot free: load the output register from the accumulator plus the current byte, clear the accumulator, set `idx=0`, stay in FILL.
    - Completing accept with slot not free: latch the byte into the accumulator and go to HOLD.
  - HOLD: `in_ready=0`. When the slot is free, transfer the accumulator to the output register, clear the accumulator, set `idx=0`, and go to FILL.
- Partial words (`in_last` before lane `LANES-1`) have unfilled lanes zero and their mask bits zero.
  - Example: `in_last` on the first byte gives mask `1000`.
- `out_valid` clears on `out_valid && out_ready` unless a new word loads in the same cycle. In that case it stays 1 and the data updates.
- `out_lanes`/`out_mask` are stable while `out_valid && !out_ready`.
- `in_ready` is a registered-state decode only. It never depends on `in_valid`, `in_last`, or `out_ready`.
- Reset values: state=FILL, `idx`=0, accumulator=0, `out_valid`=0, `out_lanes`=0, `out_mask`=0.
- Reset asserted mid-word or mid-HOLD discards all partial and pending data with no output.

## Timing
- Latency: completing byte accepted at edge N → `out_valid`=1 after edge N (visible in cycle N+1), provided the slot is free.
- Throughput: with `out_ready` held at 1, one word every `LANES` cycles and zero bubbles on the input.
- Backpressure: the completing byte is still accepted when the slot is busy. After that, `in_ready` drops for the cycles spent in HOLD and returns to 1 in the cycle after the transfer.
- Simultaneous output drain and completing accept in the same cycle: the slot counts as free, and the new word is valid in the next cycle with no gap.
- `idx` wraps from `LANES-1` to 0 on every completing byte. `in_last` at `idx == LANES-1` produces a full mask, identical to a normal full word.

## Structure
- Package `byte_packer_pkg` holds:
  - the FSM state encoding (FILL, HOLD);
  - helper localparams derived from `LANES`/`LANE_WIDTH`: `IDX_WIDTH=$clog2(LANES)` and `CONCAT_WIDTH=LANES*(LANE_WIDTH+1)`.
- Sub-module `packer_out_reg` is the output valid/ready register slice: parameterised width, load/hold/drain logic, and a `free` output.
- The top level contains the accumulator, the index counter, the FSM, and the concat assignment.

## Test plan
- **Full word.** Reset, then stream bytes `0x11,0x22,0x33,0x44` with `out_ready=1`. Required response:
  - `out_valid` in the cycle after the fourth accept;
  - `out_lanes = 0x11223344`, `out_mask = 1111`;
  - `out_concat = 0x11223344F` (36 bits).
- **Partial word.** `0xAA` then `0xBB` with `in_last` on the second byte. Required: `out_lanes = 0xAABB0000`, `out_mask = 1100`. The next word starts at lane 0.
- **Backpressure.** Hold `out_ready=0`, then send 8 bytes `0x01..0x08`. Required:
  - the first word is held stable;
  - the second word's fourth byte is accepted, then `in_ready=0` (HOLD).
  - On raising `out_ready`: word `0x01020304` is consumed, then `0x05060708` is valid in the next cycle, and `in_ready` returns to 1.
- **Back-to-back.** 16 bytes with continuous `in_valid` and `out_ready`. Required: `in_ready` is never low, 4 words are produced at a 4-cycle spacing, and the data is in order.
- **Reset mid-word.** Send 2 bytes, assert `reset` for 1 cycle, then send `0x55,0x66,0x77,0x88`. Required: only `0x55667788`/`1111` appears.
- **`in_last` on the first byte.** Byte `0xFE` with `in_last` and `out_ready=1`. Required: `out_lanes = 0xFE000000`, `out_mask = 1000`, `out_concat` low nibble = `1000`.
